// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN-channel 2-flop sync, hysteresis debounce, press/release/long/repeat strobes paced by sample_en (clk, rst_n, sample_en, btn_in -> btn_level/press/release/long/repeat)
module button_conditioner #(
  parameter int N_BTN        = 2,
  parameter int DB_DEPTH     = 4,
  parameter int HOLD_TICKS   = 16,
  parameter int REPEAT_TICKS = 4,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);
  localparam int MX = HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TICKS - 1);
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
  logic [N_BTN-1:0] s1, s2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DB_DEPTH-1:0] sh, sh_n;
    logic lv, lv_n, pr_n, rl_n, lg_n, rp_n;
    logic pr_q, rl_q, lg_q, rp_q;
    always_comb begin
      sh_n = {sh[DB_DEPTH-2:0], s2[i]};
      lv_n = &sh_n ? 1'b1 : ~|sh_n ? 1'b0 : lv;
      st_n = st;
      cnt_n = cnt;
      pr_n = 1'b0;
      rl_n = 1'b0;
      lg_n = 1'b0;
      rp_n = 1'b0;
      case (st)
        IDLE: if (lv_n) begin
          st_n = PRESS;
          cnt_n = '0;
          pr_n = 1'b1;
        end
        PRESS: if (!lv_n) begin
          st_n = IDLE;
          rl_n = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          st_n = HELD;
          cnt_n = '0;
          lg_n = 1'b1;
          rp_n = 1'b1;
        end else cnt_n = cnt + CW'(1);
        HELD: if (!lv_n) begin
          st_n = IDLE;
          rl_n = 1'b1;
        end else if (REPEAT_EN && cnt == REP_LAST) begin
          cnt_n = '0;
          rp_n = 1'b1;
        end else cnt_n = REPEAT_EN ? cnt + CW'(1) : cnt;
        default: st_n = IDLE;
      endcase
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st <= IDLE;
        cnt <= '0;
        sh <= '0;
        lv <= 1'b0;
        pr_q <= 1'b0;
        rl_q <= 1'b0;
        lg_q <= 1'b0;
        rp_q <= 1'b0;
      end else begin
        pr_q <= sample_en & pr_n;
        rl_q <= sample_en & rl_n;
        lg_q <= sample_en & lg_n;
        rp_q <= sample_en & rp_n;
        if (sample_en) begin
          st <= st_n;
          cnt <= cnt_n;
          sh <= sh_n;
          lv <= lv_n;
        end
      end
    end
    assign btn_level[i] = lv;
    assign btn_press[i] = pr_q;
    assign btn_release[i] = rl_q;
    assign btn_long[i] = lg_q;
    assign btn_repeat[i] = rp_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenario bench for button_conditioner (2 channels, sample_en every 4th clk)
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n, sample_en;
  logic [1:0] btn_in, btn_level, btn_press, btn_release, btn_long, btn_repeat;
  int cmp = 0, err = 0, smp = 0, n_bad = 0;
  int n_press[2], n_rel[2], n_long[2], n_rep[2];
  int press_at[2], rel_at[2], long_at[2], rep_first[2], rep_last[2];
  button_conditioner #(.N_BTN(2), .DB_DEPTH(4), .HOLD_TICKS(16), .REPEAT_TICKS(4), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );
  always #5 clk = ~clk;
  task automatic clr();
    smp = 0;
    for (int c = 0; c < 2; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
      press_at[c] = -1; rel_at[c] = -1; long_at[c] = -1; rep_first[c] = -1; rep_last[c] = -1;
    end
  endtask
  task automatic step(input logic [1:0] b);
    btn_in = b;
    for (int k = 0; k < 4; k++) begin
      sample_en = (k == 3);
      @(posedge clk);
      #1;
      if (k < 3 && |{btn_press, btn_release, btn_long, btn_repeat}) n_bad++;
      if (k == 3)
        for (int c = 0; c < 2; c++) begin
          if (btn_press[c]) begin n_press[c]++; press_at[c] = smp; end
          if (btn_release[c]) begin n_rel[c]++; rel_at[c] = smp; end
          if (btn_long[c]) begin n_long[c]++; long_at[c] = smp; end
          if (btn_repeat[c]) begin
            if (n_rep[c] == 0) rep_first[c] = smp;
            n_rep[c]++;
            rep_last[c] = smp;
          end
        end
    end
    sample_en = 1'b0;
    smp++;
  endtask
  task automatic release_all();
    repeat (6) step(2'b00);
    clr();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    btn_in = 2'b00;
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 10'b0) begin
      err++; $display("FAIL reset_outputs: got %b want 0", {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    rst_n = 1'b1;
    clr();
  endtask
  task automatic test_bounce();
    logic v[9];
    v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 5; j++) step({1'b0, v[j]});
    cmp++;
    if (btn_level[0] !== 1'b0 || n_press[0] !== 0) begin
      err++; $display("FAIL bounce_early: level %b presses %0d want 0 0", btn_level[0], n_press[0]);
    end
    for (int j = 5; j < 9; j++) step({1'b0, v[j]});
    cmp++;
    if (n_press[0] !== 1 || press_at[0] !== 8) begin
      err++; $display("FAIL bounce_press: count %0d at %0d want 1 at 8", n_press[0], press_at[0]);
    end
    cmp++;
    if (btn_level[0] !== 1'b1 || n_rel[0] !== 0) begin
      err++; $display("FAIL bounce_level: level %b releases %0d want 1 0", btn_level[0], n_rel[0]);
    end
  endtask
  task automatic test_short();
    repeat (8) step(2'b01);
    repeat (6) step(2'b00);
    cmp++;
    if (n_press[0] !== 1 || press_at[0] !== 3) begin
      err++; $display("FAIL short_press: count %0d at %0d want 1 at 3", n_press[0], press_at[0]);
    end
    cmp++;
    if (n_rel[0] !== 1 || rel_at[0] !== 11) begin
      err++; $display("FAIL short_release: count %0d at %0d want 1 at 11", n_rel[0], rel_at[0]);
    end
    cmp++;
    if (n_long[0] !== 0 || n_rep[0] !== 0 || btn_level[0] !== 1'b0) begin
      err++; $display("FAIL short_nolong: long %0d rep %0d level %b want 0 0 0", n_long[0], n_rep[0], btn_level[0]);
    end
  endtask
  task automatic test_hold();
    repeat (34) step(2'b01);
    cmp++;
    if (n_long[0] !== 1 || long_at[0] !== 19) begin
      err++; $display("FAIL hold_long: count %0d at %0d want 1 at 19", n_long[0], long_at[0]);
    end
    cmp++;
    if (n_rep[0] !== 4 || rep_first[0] !== 19 || rep_last[0] !== 31) begin
      err++; $display("FAIL hold_repeat: count %0d first %0d last %0d want 4 19 31", n_rep[0], rep_first[0], rep_last[0]);
    end
    repeat (4) step(2'b00);
    cmp++;
    if (n_rel[0] !== 1 || rel_at[0] !== 37) begin
      err++; $display("FAIL hold_release: count %0d at %0d want 1 at 37", n_rel[0], rel_at[0]);
    end
  endtask
  task automatic test_glitch();
    repeat (21) step(2'b01);
    step(2'b00);
    repeat (7) step(2'b01);
    cmp++;
    if (btn_level[0] !== 1'b1 || n_rel[0] !== 0) begin
      err++; $display("FAIL glitch_level: level %b releases %0d want 1 0", btn_level[0], n_rel[0]);
    end
    cmp++;
    if (n_rep[0] !== 3 || rep_last[0] !== 27 || long_at[0] !== 19) begin
      err++; $display("FAIL glitch_cadence: rep %0d last %0d long %0d want 3 27 19", n_rep[0], rep_last[0], long_at[0]);
    end
  endtask
  task automatic test_dual();
    repeat (16) step(2'b11);
    repeat (5) step(2'b01);
    cmp++;
    if (n_press[0] !== 1 || n_press[1] !== 1 || press_at[1] !== 3) begin
      err++; $display("FAIL dual_press: ch0 %0d ch1 %0d at %0d want 1 1 at 3", n_press[0], n_press[1], press_at[1]);
    end
    cmp++;
    if (n_long[0] !== 1 || long_at[0] !== 19 || n_rep[0] !== 1) begin
      err++; $display("FAIL dual_ch0_long: long %0d at %0d rep %0d want 1 at 19 rep 1", n_long[0], long_at[0], n_rep[0]);
    end
    cmp++;
    if (n_rel[1] !== 1 || rel_at[1] !== 19 || n_long[1] !== 0 || n_rep[1] !== 0) begin
      err++; $display("FAIL dual_ch1_release: rel %0d at %0d long %0d rep %0d want 1 at 19 0 0", n_rel[1], rel_at[1], n_long[1], n_rep[1]);
    end
  endtask
  task automatic test_reset_mid();
    repeat (23) step(2'b01);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== 10'b0) begin
      err++; $display("FAIL midreset_outputs: got %b want 0", {btn_level, btn_press, btn_release, btn_long, btn_repeat});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    repeat (20) step(2'b01);
    cmp++;
    if (n_press[0] !== 1 || press_at[0] !== 3 || n_rel[0] !== 0) begin
      err++; $display("FAIL midreset_press: count %0d at %0d rel %0d want 1 at 3 rel 0", n_press[0], press_at[0], n_rel[0]);
    end
    cmp++;
    if (n_long[0] !== 1 || long_at[0] !== 19 || btn_level[0] !== 1'b1) begin
      err++; $display("FAIL midreset_long: count %0d at %0d level %b want 1 at 19 level 1", n_long[0], long_at[0], btn_level[0]);
    end
  endtask
  initial begin
    test_reset();
    test_bounce();
    release_all();
    test_short();
    release_all();
    test_hold();
    release_all();
    test_glitch();
    release_all();
    test_dual();
    release_all();
    test_reset_mid();
    cmp++;
    if (n_bad !== 0) begin
      err++; $display("FAIL strobe_off_sample: got %0d strobes without sample_en want 0", n_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
